sobel_window_sequencer: RTL
===========================

# sobel_window_sequencer

Streaming controller that drives the Sobel custom-instruction datapath across a raster-scanned grayscale frame. It accepts one 8-bit pixel per handshake and keeps two line buffers plus a 3x3 shift window. For every pixel that completes a full 3x3 window, it issues one Sobel custom-instruction operation, then presents the captured result on an output handshake. It sits between the pixel source (camera/DMA) and the Sobel CI, so the CPU does not have to pack and issue every window itself.

## Interface
- `LINE_WIDTH`, 16: pixels per image line, ≥3.
- `customInstructionId`, 8'd0: id driven on `ciIseId` during an operation.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `frameStart` in 1: marks the accepted pixel as (row 0, col 0).
- `pixelValid` in 1: source has a pixel.
- `pixelIn` in 8: grayscale pixel.
- `pixelReady` out 1: block accepts a pixel this cycle.
- `ciStart` out 1: one-cycle operation pulse to the Sobel CI.
- `ciValueA` out 32: {p3,p2,p1,p0}.
- `ciValueB` out 32: {p8,p7,p6,p5}.
- `ciIseId` out 8: custom-instruction id.
- `ciDone` in 1: CI result valid. May be high in the same cycle as `ciStart`.
- `ciResult` in 32: CI result.
- `edgeValid` out 1: `edgeOut` holds a result.
- `edgeOut` out 32: captured `ciResult`.
- `outReady` in 1: consumer takes `edgeOut`.
- `busy` out 1: state ≠ ACCEPT.

## Operation
- Window pixels p0..p8 are row-major with p0 at top-left: rows r-2..r, cols c-2..c. The centre pixel p4 is not sent.
- A pixel is accepted when `pixelValid && pixelReady`.
  - The pixel enters the window column and the line buffers at column `col`.
  - If `frameStart` is high, the pixel is treated as (0,0). Line buffers are not cleared, because stale data is masked by row gating.
- Counters:
  - `col` counts 0..LINE_WIDTH-1 and wraps to 0.
  - `row` increments on wrap and saturates at 2. Only the condition row ≥ 2 is needed.
- A window is valid when the accepted pixel has row ≥ 2 and col ≥ 2. Columns 0 and 1 of every line never issue. There is no edge padding.
- FSM states: ACCEPT, ISSUE, WAIT, OUTPUT.
  - ACCEPT: `pixelReady`=1. On an accept with a valid window, go to ISSUE; otherwise stay in ACCEPT.
  - ISSUE: `ciStart`=1 for exactly this cycle; `ciValueA`/`ciValueB` hold the window and `ciIseId`=customInstructionId. If `ciDone`, capture `ciResult` and go to OUTPUT; else go to WAIT.
  - WAIT: `ciStart`=0; values and id are held stable. On `ciDone`, capture and go to OUTPUT. There is no timeout.
  - OUTPUT: `edgeValid`=1. On `outReady`, go to ACCEPT.
- Outside ISSUE/WAIT, `ciValueA`, `ciValueB` and `ciIseId` are driven to 0.
- `frameStart` is only sampled on an accept, so an in-flight result always completes before a new frame starts.
- Reset, asynchronous at any point including mid-WAIT or mid-OUTPUT:
  - FSM goes to ACCEPT; `row` and `col` go to 0.
  - `ciStart`, `edgeValid`, `ciValueA`, `ciValueB`, `ciIseId`, `edgeOut` and `busy` go to 0.
  - `pixelReady`=0 while `reset` is high and 1 in the first cycle after release.
  - A CI `ciDone` that arrives after reset is ignored.

## Timing
- Accept without a window: 1 pixel/cycle, no bubbles.
- Accept with a window at cycle t, CI done in ISSUE, `outReady`=1:
  - ISSUE at t+1, OUTPUT at t+2, next accept at t+3.
  - Windowed throughput is 1 pixel per 3 cycles.
- Each extra CI cycle adds one WAIT cycle.
- `outReady` low stalls OUTPUT. `edgeOut` stays stable and `pixelReady` stays 0.
- `edgeOut` is registered on the capture edge; `edgeValid` rises the following cycle.

## Structure
- Shared package/include `sobel_pkg`: FSM state encoding, PIXEL_W=8, the window-index constants p0..p8, and the packing helper for {p3,p2,p1,p0}/{p8,p7,p6,p5}. This packing is shared with software and the CI.
- Sub-module `sobel_line_buffer`:
  - LINE_WIDTH×8 register line, indexed by `col`.
  - Read-before-write on accept.
  - Instantiated twice; the first buffer's output feeds the second.
- The top level holds the FSM, counters, 3×3 shift registers, output register and the CI interface.

## Test plan
- **Reset:** assert `reset` mid-frame. All outputs are 0 during reset; `pixelReady`=1 in the cycle after release; no `ciStart` occurs.
- **First window (LINE_WIDTH=4):** feed pixels 0..10 (value = index), with `frameStart` on pixel 0. No `ciStart` for pixels 0..9. After pixel 10, `ciStart` pulses once with `ciValueA`=0x04020100, `ciValueB`=0x0A090806, `ciIseId`=customInstructionId.
- **Same-cycle done:** `ciDone`=1 in ISSUE with `ciResult`=0x0000012C. `edgeValid` is high one cycle later, `edgeOut`=0x0000012C, and a total of 3 cycles elapse from accept to the next accept.
- **Delayed done and backpressure:**
  - `ciDone` arrives 3 cycles after `ciStart`. `ciStart` is high exactly 1 cycle and `ciValueA`/`ciValueB` stay stable until done.
  - Then hold `outReady`=0 for 5 cycles. `edgeValid` and `edgeOut` are held and `pixelReady` stays 0.
- **Line wrap:**
  - Continue into row 3. Pixels at cols 0 and 1 produce no `ciStart`; col 2 issues with the rows 1..3 window.
  - Assert `frameStart` mid-line. The next 2×LINE_WIDTH+2 pixels produce no `ciStart`.
- **Reset in WAIT:** assert `reset` while in WAIT, then pulse `ciDone`. No `edgeValid` occurs and the state is ACCEPT.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel window sequencer: FSM encoding, window indices
// and the operand packing that software and the Sobel CI also rely on.
package sobel_pkg;

  localparam int PIXEL_W = 8;

  // Window positions, row-major with p0 at top-left.
  localparam int P0 = 0;
  localparam int P1 = 1;
  localparam int P2 = 2;
  localparam int P3 = 3;
  localparam int P4 = 4;
  localparam int P5 = 5;
  localparam int P6 = 6;
  localparam int P7 = 7;
  localparam int P8 = 8;

  typedef logic [PIXEL_W-1:0] pixel_t;
  typedef logic [8:0][PIXEL_W-1:0] window_t;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_OUTPUT = 2'd3
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] pack_a(input window_t w);
    return {w[P3], w[P2], w[P1], w[P0]};
  endfunction

  function automatic logic [31:0] pack_b(input window_t w);
    return {w[P8], w[P7], w[P6], w[P5]};
  endfunction

endpackage

// File: rtl/sobel_window_sequencer_if.sv
// Pixel-in, CI and edge-out signals of the Sobel window sequencer.
interface sobel_window_sequencer_if;
  import sobel_pkg::*;

  // Handshakes: a pixel transfers on a rising edge where pixelValid && pixelReady;
  // an edge result transfers where edgeValid && outReady; edgeValid/edgeOut hold
  // until taken. ciStart is a one-cycle request, ciDone a one-cycle completion.
  logic        frameStart;
  logic        pixelValid;
  pixel_t      pixelIn;
  logic        pixelReady;
  logic        ciStart;
  logic [31:0] ciValueA;
  logic [31:0] ciValueB;
  logic [7:0]  ciIseId;
  logic        ciDone;
  logic [31:0] ciResult;
  logic        edgeValid;
  logic [31:0] edgeOut;
  logic        outReady;
  logic        busy;

  // master: the surroundings (pixel source, CI, consumer); slave: the sequencer.
  modport master (
    output frameStart, pixelValid, pixelIn, ciDone, ciResult, outReady,
    input  pixelReady, ciStart, ciValueA, ciValueB, ciIseId, edgeValid, edgeOut, busy
  );

  modport slave (
    input  frameStart, pixelValid, pixelIn, ciDone, ciResult, outReady,
    output pixelReady, ciStart, ciValueA, ciValueB, ciIseId, edgeValid, edgeOut, busy
  );

endinterface

// File: rtl/sobel_line_buffer.sv
// One image line of pixels indexed by column; read-before-write so the output is
// the pixel stored one line earlier at the same column.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter  int LINE_WIDTH = 16,
  localparam int IDX_W      = idx_w(LINE_WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  pixel_t           din,
  output pixel_t           dout
);

  pixel_t mem [LINE_WIDTH];

  assign dout = mem[idx];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LINE_WIDTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[idx] <= din;
    end
  end

endmodule

// File: rtl/sobel_window_sequencer.sv
// Builds 3x3 windows from a raster pixel stream, issues one Sobel CI operation per
// complete window and hands the captured result to the consumer.
module sobel_window_sequencer
  import sobel_pkg::*;
#(
  parameter int         LINE_WIDTH          = 16,
  parameter logic [7:0] customInstructionId = 8'd0
) (
  input  logic                      clock,
  input  logic                      reset,
  sobel_window_sequencer_if.slave   bus,
  output state_t                    state_dbg
);

  localparam int               COL_W    = idx_w(LINE_WIDTH);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_WIDTH - 1);

  state_t           state;
  logic [COL_W-1:0] col;
  logic [1:0]       row;
  window_t          win;

  logic        ready_q;
  logic        ci_start_q;
  logic        edge_valid_q;
  logic        busy_q;
  logic [31:0] value_a_q;
  logic [31:0] value_b_q;
  logic [7:0]  ise_id_q;
  logic [31:0] edge_out_q;

  logic             accept;
  logic [COL_W-1:0] col_eff;
  logic [COL_W-1:0] col_next;
  logic [1:0]       row_eff;
  logic [1:0]       row_next;
  logic             window_ok;
  pixel_t           top_px;
  pixel_t           mid_px;
  window_t          win_next;

  assign accept = (state == ST_ACCEPT) && ready_q && bus.pixelValid;

  // frameStart re-homes the accepted pixel to (0,0); stale line data is never
  // used because row gating keeps the first two lines from issuing.
  always_comb begin
    col_eff   = bus.frameStart ? '0 : col;
    row_eff   = bus.frameStart ? 2'd0 : row;
    window_ok = (row_eff == 2'd2) && (col_eff >= COL_W'(2));
    col_next  = (col_eff == LAST_COL) ? '0 : col_eff + COL_W'(1);
    row_next  = ((col_eff == LAST_COL) && (row_eff != 2'd2)) ? row_eff + 2'd1 : row_eff;
  end

  always_comb begin
    win_next     = win;
    win_next[P0] = win[P1];
    win_next[P1] = win[P2];
    win_next[P2] = top_px;
    win_next[P3] = win[P4];
    win_next[P4] = win[P5];
    win_next[P5] = mid_px;
    win_next[P6] = win[P7];
    win_next[P7] = win[P8];
    win_next[P8] = bus.pixelIn;
  end

  sobel_line_buffer #(.LINE_WIDTH(LINE_WIDTH)) u_line_mid (
    .clock (clock),
    .reset (reset),
    .we    (accept),
    .idx   (col_eff),
    .din   (bus.pixelIn),
    .dout  (mid_px)
  );

  sobel_line_buffer #(.LINE_WIDTH(LINE_WIDTH)) u_line_top (
    .clock (clock),
    .reset (reset),
    .we    (accept),
    .idx   (col_eff),
    .din   (mid_px),
    .dout  (top_px)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_ACCEPT;
      col          <= '0;
      row          <= 2'd0;
      win          <= '0;
      ready_q      <= 1'b0;
      ci_start_q   <= 1'b0;
      edge_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      value_a_q    <= '0;
      value_b_q    <= '0;
      ise_id_q     <= '0;
      edge_out_q   <= '0;
    end else begin
      if (accept) begin
        win <= win_next;
        col <= col_next;
        row <= row_next;
      end
      case (state)
        ST_ACCEPT: begin
          ready_q <= 1'b1;
          if (accept && window_ok) begin
            state      <= ST_ISSUE;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            ci_start_q <= 1'b1;
            value_a_q  <= pack_a(win_next);
            value_b_q  <= pack_b(win_next);
            ise_id_q   <= customInstructionId;
          end
        end
        ST_ISSUE: begin
          ci_start_q <= 1'b0;
          if (bus.ciDone) begin
            state        <= ST_OUTPUT;
            edge_out_q   <= bus.ciResult;
            edge_valid_q <= 1'b1;
            value_a_q    <= '0;
            value_b_q    <= '0;
            ise_id_q     <= '0;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.ciDone) begin
            state        <= ST_OUTPUT;
            edge_out_q   <= bus.ciResult;
            edge_valid_q <= 1'b1;
            value_a_q    <= '0;
            value_b_q    <= '0;
            ise_id_q     <= '0;
          end
        end
        ST_OUTPUT: begin
          if (bus.outReady) begin
            state        <= ST_ACCEPT;
            edge_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b1;
          end
        end
        default: state <= ST_ACCEPT;
      endcase
    end
  end

  assign bus.pixelReady = ready_q;
  assign bus.ciStart    = ci_start_q;
  assign bus.ciValueA   = value_a_q;
  assign bus.ciValueB   = value_b_q;
  assign bus.ciIseId    = ise_id_q;
  assign bus.edgeValid  = edge_valid_q;
  assign bus.edgeOut    = edge_out_q;
  assign bus.busy       = busy_q;
  assign state_dbg      = state;

endmodule
